// File: rtl/jac_pkg.sv
// Shared widths, opcodes, status bit indices and FSM encoding for the JAC
// control unit and its companion ALU_J.
package jac_pkg;

    localparam int DATA_W   = 8;
    localparam int OPC_W    = 5;
    localparam int PARAM_W  = 8;
    localparam int STAT_W   = 6;
    localparam int PC_W     = 8;
    localparam int INSTR_W  = 24;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    localparam int ST_CARRY = 0;
    localparam int ST_UNDER = 1;
    localparam int ST_ZERO  = 2;
    localparam int ST_EQUAL = 3;
    localparam int ST_GT    = 4;
    localparam int ST_ST    = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h01,
        OP_SUB  = 5'h02,
        OP_AND  = 5'h03,
        OP_OR   = 5'h04,
        OP_NOT  = 5'h05,
        OP_XOR  = 5'h06,
        OP_SHL  = 5'h07,
        OP_SHR  = 5'h08,
        OP_VAL  = 5'h09,
        OP_GOTO = 5'h10,
        OP_IFZ  = 5'h11,
        OP_IFNZ = 5'h12,
        OP_IFEQ = 5'h13,
        OP_IFST = 5'h14,
        OP_IFGT = 5'h15
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_e;

    typedef struct packed {
        logic rf_we;
        logic wr_param;
        logic status_we;
        logic jump;
        logic illegal;
    } exec_ctl_t;

    // Commit controls for the instruction in EXEC; branch conditions look at
    // the status left behind by earlier instructions.
    function automatic exec_ctl_t exec_decode(input logic [OPC_W-1:0]  op,
                                              input logic [STAT_W-1:0] st);
        exec_ctl_t c;
        c = '0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_NOT, OP_XOR, OP_SHL, OP_SHR: begin
                c.rf_we     = 1'b1;
                c.status_we = 1'b1;
            end
            OP_VAL: begin
                c.rf_we    = 1'b1;
                c.wr_param = 1'b1;
            end
            OP_GOTO: c.jump = 1'b1;
            OP_IFZ:  c.jump = st[ST_ZERO];
            OP_IFNZ: c.jump = ~st[ST_ZERO];
            OP_IFEQ: c.jump = st[ST_EQUAL];
            OP_IFST: c.jump = st[ST_ST];
            OP_IFGT: c.jump = st[ST_GT];
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/jac_regfile.sv
// Register file r0..r7: two combinational read ports, one synchronous write
// port, all entries cleared by the asynchronous reset.
module jac_regfile
    import jac_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int NumRegs   = NUM_REGS,
    parameter int AddrWidth = REG_AW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [AddrWidth-1:0] raddr1,
    output logic [DataWidth-1:0] rdata1,
    input  logic [AddrWidth-1:0] raddr2,
    output logic [DataWidth-1:0] rdata2,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata
);

    logic [NumRegs-1:0][DataWidth-1:0] regs;

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/jac_control_unit.sv
// JAC control unit: three-state fetch/decode/execute sequencer driving an
// external combinational ALU and committing its results.
module jac_control_unit
    import jac_pkg::*;
#(
    parameter int DataWidth     = DATA_W,
    parameter int NumOpCodeBits = OPC_W,
    parameter int ParamBits     = PARAM_W,
    parameter int NumStatusBits = STAT_W,
    parameter int PcWidth       = PC_W,
    parameter int InstrWidth    = INSTR_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run,
    output logic                     instr_req,
    output logic [PcWidth-1:0]       instr_addr,
    input  logic                     instr_ack,
    input  logic [InstrWidth-1:0]    instr_data,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic [PcWidth-1:0]       pc,
    output logic [NumStatusBits-1:0] status_reg,
    output logic                     illegal_op
);

    localparam int OpLsb = InstrWidth - NumOpCodeBits;
    localparam int RaLsb = OpLsb - REG_AW;
    localparam int RbLsb = RaLsb - REG_AW;

    state_e                   state, state_nxt;
    logic [InstrWidth-1:0]    ir;
    logic [NumOpCodeBits-1:0] ir_op;
    logic [REG_AW-1:0]        ir_ra, ir_rb;
    logic [ParamBits-1:0]     ir_param;
    logic [DataWidth-1:0]     rd1, rd2, rf_wdata;
    logic                     rf_we, fetch_fire;
    logic [PcWidth-1:0]       pc_nxt;
    exec_ctl_t                ctl;
    logic                     unused_ir_bits;

    assign ir_op    = ir[OpLsb +: NumOpCodeBits];
    assign ir_ra    = ir[RaLsb +: REG_AW];
    assign ir_rb    = ir[RbLsb +: REG_AW];
    assign ir_param = ir[ParamBits-1:0];
    assign unused_ir_bits = ^ir[RbLsb-1:ParamBits];

    assign instr_req  = (state == S_FETCH) && run;
    assign instr_addr = pc;
    assign fetch_fire = instr_req && instr_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (fetch_fire) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // ra stays valid in ir through EXEC, so it doubles as the write address.
    always_comb begin
        ctl      = exec_decode(alu_opcode, status_reg);
        rf_we    = (state == S_EXEC) && ctl.rf_we;
        rf_wdata = ctl.wr_param ? DataWidth'(alu_param) : alu_result;
        pc_nxt   = ctl.jump ? PcWidth'(alu_param) : pc + PcWidth'(1);
    end

    jac_regfile #(
        .DataWidth (DataWidth),
        .NumRegs   (NUM_REGS),
        .AddrWidth (REG_AW)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .raddr1  (ir_ra),
        .rdata1  (rd1),
        .raddr2  (ir_rb),
        .rdata2  (rd2),
        .we      (rf_we),
        .waddr   (ir_ra),
        .wdata   (rf_wdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir           <= '0;
            alu_opcode   <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_param    <= '0;
            pc           <= '0;
            status_reg   <= '0;
            illegal_op   <= 1'b0;
        end else begin
            if (fetch_fire) ir <= instr_data;
            if (state == S_DECODE) begin
                alu_opcode   <= ir_op;
                alu_operand1 <= rd1;
                alu_operand2 <= rd2;
                alu_param    <= ir_param;
            end
            if (state == S_EXEC) begin
                pc <= pc_nxt;
                if (ctl.status_we) status_reg <= alu_status;
                if (ctl.illegal)   illegal_op <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jac_control_unit.sv
// Directed and randomized bench for jac_control_unit with an ISA-level
// reference model and a behavioural ALU on the ALU ports.
module tb_jac_control_unit;
    import jac_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n, run, instr_req, instr_ack, illegal_op;
    logic [7:0]  instr_addr, alu_operand1, alu_operand2, alu_param, alu_result, pc;
    logic [23:0] instr_data;
    logic [4:0]  alu_opcode;
    logic [5:0]  alu_status, status_reg;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] m_r [8];
    logic [7:0] m_pc;
    logic [5:0] m_st;
    logic       m_ill;

    always #5 clock = ~clock;

    jac_control_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_ack    (instr_ack),
        .instr_data   (instr_data),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_param    (alu_param),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .pc           (pc),
        .status_reg   (status_reg),
        .illegal_op   (illegal_op)
    );

    // {status[5:0], result[7:0]}; status = {ST, GT, EQ, Zero, Underflow, Carry}
    function automatic logic [13:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic c, u;
        w = '0; r = '0; c = 1'b0; u = 1'b0;
        case (op)
            5'h01: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
            5'h02: begin r = a - b; u = (a < b); end
            5'h03: r = a & b;
            5'h04: r = a | b;
            5'h05: r = ~a;
            5'h06: r = a ^ b;
            5'h07: begin r = {a[6:0], 1'b0}; c = a[7]; end
            5'h08: r = {1'b0, a[7:1]};
            default: r = '0;
        endcase
        return {(a < b), (a > b), (a == b), (r == 8'h00), u, c, r};
    endfunction

    always_comb {alu_status, alu_result} = alu_f(alu_opcode, alu_operand1, alu_operand2);

    function automatic logic [23:0] enc(input logic [4:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [7:0] p);
        return {op, ra, rb, 5'b0, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_pc = 8'h00; m_st = 6'h00; m_ill = 1'b0;
    endtask

    task automatic mdl_exec(input logic [23:0] ins);
        logic [4:0]  op;
        logic [2:0]  ra, rb;
        logic [7:0]  p;
        logic [13:0] a;
        logic        cond;
        op = ins[23:19]; ra = ins[18:16]; rb = ins[15:13]; p = ins[7:0];
        a = alu_f(op, m_r[ra], m_r[rb]);
        if (op >= 5'h01 && op <= 5'h08) begin
            m_r[ra] = a[7:0]; m_st = a[13:8]; m_pc = m_pc + 8'd1;
        end else if (op == 5'h00) begin
            m_pc = m_pc + 8'd1;
        end else if (op == 5'h09) begin
            m_r[ra] = p; m_pc = m_pc + 8'd1;
        end else if (op == 5'h10) begin
            m_pc = p;
        end else if (op >= 5'h11 && op <= 5'h15) begin
            case (op)
                5'h11:   cond = m_st[2];
                5'h12:   cond = !m_st[2];
                5'h13:   cond = m_st[3];
                5'h14:   cond = m_st[5];
                default: cond = m_st[4];
            endcase
            m_pc = cond ? p : m_pc + 8'd1;
        end else begin
            m_ill = 1'b1; m_pc = m_pc + 8'd1;
        end
    endtask

    // Entered #1 after a rising edge with the DUT in FETCH; leaves the same way.
    task automatic do_instr(input logic [23:0] ins, input int wait_n, input bit drop_run);
        #1;
        chk("fetch_req", instr_req, 1);
        chk("fetch_addr", instr_addr, m_pc);
        instr_data = ins;
        instr_ack  = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            @(posedge clock); #1;
            chk("wait_req", instr_req, 1);
            chk("wait_addr", instr_addr, m_pc);
        end
        instr_ack = 1'b1;
        @(posedge clock); #1;
        instr_ack  = 1'b0;
        instr_data = 24'($urandom);
        if (drop_run) run = 1'b0;
        chk("decode_req", instr_req, 0);
        @(posedge clock); #1;
        chk("dec_opcode", alu_opcode, ins[23:19]);
        chk("dec_op1", alu_operand1, m_r[ins[18:16]]);
        chk("dec_op2", alu_operand2, m_r[ins[15:13]]);
        chk("dec_param", alu_param, ins[7:0]);
        @(posedge clock); #1;
        mdl_exec(ins);
        chk("exec_pc", pc, m_pc);
        chk("exec_status", status_reg, m_st);
        chk("exec_illegal", illegal_op, m_ill);
        chk("next_req", instr_req, drop_run ? 0 : 1);
    endtask

    // run low with a spurious ack: nothing may be fetched.
    task automatic idle(input int n);
        instr_ack  = 1'b1;
        instr_data = enc(OP_GOTO, 3'd0, 3'd0, 8'hEE);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            chk("idle_req", instr_req, 0);
            chk("idle_pc", pc, m_pc);
        end
        instr_ack = 1'b0;
        run = 1'b1;
    endtask

    initial begin
        logic [23:0] ins;
        reset_n = 1'b0; run = 1'b0; instr_ack = 1'b0; instr_data = '0;
        mdl_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_status", status_reg, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_req", instr_req, 0);
        chk("rst_alu", {alu_opcode, alu_operand1, alu_operand2, alu_param}, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run = 1'b1;

        // Basic add sequence
        do_instr(enc(OP_VAL, 3'd1, 3'd0, 8'h05), 0, 0);
        do_instr(enc(OP_VAL, 3'd2, 3'd0, 8'h03), 0, 0);
        do_instr(enc(OP_ADD, 3'd1, 3'd2, 8'h00), 0, 0);
        chk("add_pc", pc, 8'h03);
        chk("add_status", status_reg, 6'b01_0000);
        do_instr(enc(OP_NOP, 3'd1, 3'd1, 8'h00), 0, 0);

        // Zero-flag branches
        do_instr(enc(OP_VAL, 3'd1, 3'd0, 8'h03), 0, 0);
        do_instr(enc(OP_VAL, 3'd2, 3'd0, 8'h03), 0, 0);
        do_instr(enc(OP_SUB, 3'd1, 3'd2, 8'h00), 0, 0);
        chk("sub_status", status_reg, 6'b00_1100);
        do_instr(enc(OP_IFZ, 3'd0, 3'd0, 8'h40), 0, 0);
        chk("ifz_pc", pc, 8'h40);
        do_instr(enc(OP_VAL, 3'd1, 3'd0, 8'h03), 0, 0);
        do_instr(enc(OP_SUB, 3'd1, 3'd2, 8'h00), 0, 0);
        do_instr(enc(OP_IFNZ, 3'd0, 3'd0, 8'h80), 0, 0);
        chk("ifnz_pc", pc, 8'h43);

        // pc wrap
        do_instr(enc(OP_GOTO, 3'd0, 3'd0, 8'hFF), 0, 0);
        chk("goto_pc", pc, 8'hFF);
        do_instr(enc(OP_NOP, 3'd0, 3'd0, 8'h00), 0, 0);
        chk("wrap_pc", pc, 8'h00);

        // Delayed ack, then run dropped mid-instruction with spurious acks
        do_instr(enc(OP_VAL, 3'd3, 3'd0, 8'h5A), 5, 0);
        do_instr(enc(OP_VAL, 3'd4, 3'd3, 8'h77), 0, 1);
        idle(3);
        do_instr(enc(OP_XOR, 3'd3, 3'd4, 8'h00), 1, 0);

        // Reserved opcode: no write, sticky flag
        do_instr(enc(5'h0B, 3'd1, 3'd2, 8'h12), 0, 0);
        chk("illegal_set", illegal_op, 1);
        do_instr(enc(OP_VAL, 3'd1, 3'd0, 8'h11), 0, 0);
        do_instr(enc(OP_VAL, 3'd2, 3'd0, 8'h22), 0, 0);
        chk("illegal_sticky", illegal_op, 1);

        // Reset during EXEC of ADD
        #1;
        instr_data = enc(OP_ADD, 3'd1, 3'd2, 8'h00);
        instr_ack  = 1'b1;
        @(posedge clock); #1;
        instr_ack = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_opcode", alu_opcode, OP_ADD);
        run = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_status", status_reg, 0);
        chk("mid_rst_illegal", illegal_op, 0);
        chk("mid_rst_req", instr_req, 0);
        chk("mid_rst_alu", {alu_opcode, alu_operand1, alu_operand2, alu_param}, 0);
        mdl_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        run = 1'b1;
        do_instr(enc(OP_NOP, 3'd1, 3'd2, 8'h00), 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            ins = {5'($urandom_range(0, 31)), 3'($urandom), 3'($urandom), 5'($urandom), 8'($urandom)};
            if ($urandom_range(0, 2) == 0) ins[23:19] = 5'($urandom_range(1, 9));
            do_instr(ins, $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
            if (!run) idle($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
